div_share_sched: RTL and testbench
==================================

Name: div_share_sched

Overview:
- Schedules one shared sequential divider among NREQ requesters in the pixel-clock video pipeline, e.g. centroid x/y, area ratio and colour ratio computed at frame end.
- Arbitrates requests round-robin and drives the divider through a start/done handshake.
- Returns each result to its owner with a one-cycle response pulse.
- Guards against a hung divider with a timeout.

Parameters:
- NREQ, 4, number of requesters (2..8).
- N, 16, operand and result width.
- TIMEOUT, 64, maximum cycles from div_start to div_done before the operation is aborted (2..65535).

Ports:
- pixelclk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request per requester; held high until accepted.
- req_dividend  in  NREQ*N  packed dividends; requester i occupies bits [i*N +: N].
- req_divisor  in  NREQ*N  packed divisors, same packing.
- req_ready  out  NREQ  one-hot accept (combinational).
- rsp_valid  out  NREQ  one-hot, one-cycle result pulse.
- rsp_quotient  out  N  result quotient; valid with rsp_valid.
- rsp_remainder  out  N  result remainder; valid with rsp_valid.
- rsp_err  out  1  result is a timeout abort; valid with rsp_valid.
- div_start  out  1  one-cycle start pulse to the divider.
- div_dividend  out  N  operand to the divider, held from ISSUE until RESP.
- div_divisor  out  N  operand to the divider, held from ISSUE until RESP.
- div_done  in  1  divider completion pulse.
- div_quotient  in  N  divider result; sampled on div_done.
- div_remainder  in  N  divider result; sampled on div_done.
- busy  out  1  high whenever state is not IDLE.
- err_sticky  out  1  set on any timeout; cleared only by reset.

Behaviour:
- Reset: state IDLE; last_grant=NREQ-1, so requester 0 has first priority; all registers and outputs 0.
- Reset asserted mid-operation aborts immediately:
  - no rsp_valid is issued;
  - a late div_done after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first requester with req_valid set, searching from (last_grant+1) mod NREQ upward with wrap.
  - req_ready[g]=1 combinationally, only in IDLE.
  - Transfer on the edge where req_valid[g]&req_ready[g]: latch g and operands, go to ISSUE.
- ISSUE: div_start=1 for exactly one cycle; go to WAIT; clear timeout counter.
- WAIT:
  - Counter increments every cycle.
  - On div_done: latch div_quotient/div_remainder, rsp_err=0, go to RESP.
  - Else when counter reaches TIMEOUT-1: latch quotient=0, remainder=0, rsp_err=1, set err_sticky, go to RESP.
  - If div_done arrives on the same cycle as the timeout, div_done wins.
- RESP: rsp_valid[g]=1 for one cycle; last_grant<=g; go to IDLE.
- div_done outside WAIT is ignored.
- Requests changing or dropping while not granted are ignored; no request is lost while req_valid stays high.
- Throughput: one operation per (divider latency + 3) cycles.
- Starvation-free: with all NREQ requesting, each is served within NREQ operations.
- rsp_quotient, rsp_remainder and rsp_err are registered and hold their value until the next RESP.

Optional Feature:
- Macro: DIV_ZERO_GUARD_EN.
- Defined:
  - A granted request with divisor==0 skips ISSUE/WAIT: IDLE -> RESP in one edge, no div_start.
  - Result: quotient = all ones, remainder = dividend, rsp_err=0.
- Undefined: zero divisors are issued to the divider like any other operand.

Test Plan:
- Single request, requester 0: 100/7, divider model latency 17 -> req_ready[0] high one cycle, div_start one pulse, rsp_valid[0] once with q=14, r=2, rsp_err=0, busy low after RESP.
- All four requesting from reset with distinct operands -> service order 0,1,2,3. Then requesters 0 and 3 request with last_grant=3 -> order 0 then 3. Each rsp_valid bit pulses exactly once per accepted request.
- Divider model never asserts div_done, TIMEOUT=64 -> rsp_valid[g] exactly 64 cycles after div_start, rsp_err=1, q=r=0, err_sticky=1; the next normal request still returns a correct result.
- Divisor 0, dividend 500, requester 2 -> with DIV_ZERO_GUARD_EN: no div_start, q=0xFFFF, r=500. Without the macro: div_start issued, divider-model result forwarded.
- rst_n pulsed low during WAIT, with div_done arriving 2 cycles after reset release -> no rsp_valid, state IDLE, stray div_done ignored, requester 0 granted first afterwards.
- div_done asserted on the same cycle as the timeout -> divider result returned, rsp_err=0, err_sticky unchanged.

Source files
------------

// File: rtl/div_share_sched_if.sv
// rtl/div_share_sched_if.sv - requester and divider buses of the shared-divider scheduler
interface div_share_sched_if #(
    parameter int NREQ = 4,
    parameter int N    = 16
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_dividend;
    logic [NREQ*N-1:0] req_divisor;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [N-1:0]      rsp_quotient;
    logic [N-1:0]      rsp_remainder;
    logic              rsp_err;
    logic              div_start;
    logic [N-1:0]      div_dividend;
    logic [N-1:0]      div_divisor;
    logic              div_done;
    logic [N-1:0]      div_quotient;
    logic [N-1:0]      div_remainder;

    // environment side: requesters plus the divider itself
    modport master (
        output req_valid, req_dividend, req_divisor,
        output div_done, div_quotient, div_remainder,
        input  req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
        input  div_start, div_dividend, div_divisor
    );

    // scheduler side
    modport slave (
        input  req_valid, req_dividend, req_divisor,
        input  div_done, div_quotient, div_remainder,
        output req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_err,
        output div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_share_sched.sv
// rtl/div_share_sched.sv - round-robin scheduler sharing one sequential divider; optional DIV_ZERO_GUARD_EN
module div_share_sched #(
    parameter int NREQ    = 4,
    parameter int N       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             pixelclk,
    input  logic             rst_n,
    div_share_sched_if.slave bus,
    output logic             busy,
    output logic             err_sticky
);
    localparam int              GW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [GW:0]     NREQ_W   = (GW+1)'(NREQ);
    localparam logic [GW-1:0]   LAST_RST = GW'(NREQ - 1);
    localparam logic [15:0]     TO_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   gnt_idx;
    logic            gnt_found;
    logic            fire;
    logic [N-1:0]    sel_dividend;
    logic [N-1:0]    sel_divisor;
    logic [N-1:0]    op_dividend;
    logic [N-1:0]    op_divisor;
    logic [N-1:0]    res_q;
    logic [N-1:0]    res_r;
    logic            res_err;
    logic [15:0]     tmo_cnt;

    // round-robin search starting one past the last served requester
    always_comb begin
        logic [GW:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_grant} + (GW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!gnt_found && bus.req_valid[cand[GW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[GW-1:0];
            end
        end
    end

    // operands of the requester currently winning arbitration
    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == GW'(i)) begin
                sel_dividend = bus.req_dividend[i*N +: N];
                sel_divisor  = bus.req_divisor[i*N +: N];
            end
        end
    end

    assign fire = (state == S_IDLE) && gnt_found;

`ifdef DIV_ZERO_GUARD_EN
    logic zero_div;
    assign zero_div = (sel_divisor == '0);
`endif

    // state register
    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic; a divider completion beats a coincident timeout
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fire) begin
`ifdef DIV_ZERO_GUARD_EN
                    state_nxt = zero_div ? S_RESP : S_ISSUE;
`else
                    state_nxt = S_ISSUE;
`endif
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.div_done || (tmo_cnt == TO_LAST)) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // outputs decoded from state; the accept is only offered while idle
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.div_start = 1'b0;
        busy          = (state != S_IDLE);
        if (state == S_IDLE && gnt_found) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
        if (state == S_ISSUE) begin
            bus.div_start = 1'b1;
        end
        if (state == S_RESP) begin
            bus.rsp_valid[grant_q] = 1'b1;
        end
    end

    // grant, operands, timeout counter and result registers; the counter
    // restarts on entry to ISSUE so the div_start cycle counts as cycle 0
    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant  <= LAST_RST;
            grant_q     <= '0;
            op_dividend <= '0;
            op_divisor  <= '0;
            tmo_cnt     <= '0;
            res_q       <= '0;
            res_r       <= '0;
            res_err     <= 1'b0;
            err_sticky  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fire) begin
                        grant_q     <= gnt_idx;
                        op_dividend <= sel_dividend;
                        op_divisor  <= sel_divisor;
                        tmo_cnt     <= '0;
`ifdef DIV_ZERO_GUARD_EN
                        if (zero_div) begin
                            res_q   <= '1;
                            res_r   <= sel_dividend;
                            res_err <= 1'b0;
                        end
`endif
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (bus.div_done) begin
                        res_q   <= bus.div_quotient;
                        res_r   <= bus.div_remainder;
                        res_err <= 1'b0;
                    end else if (tmo_cnt == TO_LAST) begin
                        res_q      <= '0;
                        res_r      <= '0;
                        res_err    <= 1'b1;
                        err_sticky <= 1'b1;
                    end
                end
                S_RESP: begin
                    last_grant <= grant_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.div_dividend  = op_dividend;
    assign bus.div_divisor   = op_divisor;
    assign bus.rsp_quotient  = res_q;
    assign bus.rsp_remainder = res_r;
    assign bus.rsp_err       = res_err;

endmodule

// File: tb/tb_div_share_sched.sv
// tb/tb_div_share_sched.sv - directed self-checking bench for div_share_sched
module tb_div_share_sched;
    localparam int NREQ    = 4;
    localparam int N       = 16;
    localparam int TIMEOUT = 64;

    logic pixelclk = 1'b0;
    logic rst_n    = 1'b0;
    logic busy;
    logic err_sticky;

    always #5 pixelclk = ~pixelclk;

    div_share_sched_if #(.NREQ(NREQ), .N(N)) bus ();

    div_share_sched #(.NREQ(NREQ), .N(N), .TIMEOUT(TIMEOUT)) dut (
        .pixelclk   (pixelclk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .err_sticky (err_sticky)
    );

    int n_vec = 0;
    int n_err = 0;

    int cyc       = 0;
    int n_start   = 0;
    int start_cyc = 0;
    int rsp_cyc   = 0;
    int bad_oh    = 0;
    logic [NREQ-1:0] acc_last = '0;
    int         acc_q[$];
    int         rsp_idx_q[$];
    logic [N-1:0] rsp_qq[$];
    logic [N-1:0] rsp_rq[$];
    logic       rsp_eq[$];

    int dm_mode       = 0;
    int dm_lat        = 5;
    int dm_stray_req  = 0;
    logic [N-1:0] dm_a, dm_b;

    function automatic int oh2i(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // observer on the falling edge: handshakes, start pulses, responses
    initial begin
        forever begin
            @(negedge pixelclk);
            cyc++;
            acc_last = rst_n ? (bus.req_valid & bus.req_ready) : '0;
            if (|acc_last) begin
                acc_q.push_back(oh2i(acc_last));
                if ($countones(bus.req_ready) != 1) bad_oh++;
            end
            if (bus.div_start) begin
                n_start++;
                start_cyc = cyc;
            end
            if (|bus.rsp_valid) begin
                if ($countones(bus.rsp_valid) != 1) bad_oh++;
                rsp_idx_q.push_back(oh2i(bus.rsp_valid));
                rsp_qq.push_back(bus.rsp_quotient);
                rsp_rq.push_back(bus.rsp_remainder);
                rsp_eq.push_back(bus.rsp_err);
                rsp_cyc = cyc;
            end
        end
    end

    // divider model: fixed latency, optional hang, optional stray completion
    initial begin
        int seen;
        seen = 0;
        bus.div_done      = 1'b0;
        bus.div_quotient  = '0;
        bus.div_remainder = '0;
        forever begin
            @(negedge pixelclk);
            if (dm_stray_req != seen) begin
                seen = dm_stray_req;
                @(posedge pixelclk); #1;
                bus.div_done      = 1'b1;
                bus.div_quotient  = 16'd777;
                bus.div_remainder = 16'd55;
                @(posedge pixelclk); #1;
                bus.div_done = 1'b0;
            end else if (bus.div_start && dm_mode == 0) begin
                dm_a = bus.div_dividend;
                dm_b = bus.div_divisor;
                repeat (dm_lat) @(posedge pixelclk);
                #1;
                bus.div_done = 1'b1;
                if (dm_b != 0) begin
                    bus.div_quotient  = dm_a / dm_b;
                    bus.div_remainder = dm_a % dm_b;
                end else begin
                    bus.div_quotient  = 16'hABCD;
                    bus.div_remainder = dm_a ^ 16'h5555;
                end
                @(posedge pixelclk); #1;
                bus.div_done = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc1();
        @(posedge pixelclk); #1;
        bus.req_valid = bus.req_valid & ~acc_last;
    endtask

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.req_dividend[i*N +: N] = a;
        bus.req_divisor[i*N +: N]  = b;
        bus.req_valid[i]           = 1'b1;
    endtask

    task automatic wait_rsp(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (rsp_idx_q.size() < n && k < budget) begin
            cyc1();
            k++;
        end
        if (rsp_idx_q.size() < n) chk({tag, "_budget"}, rsp_idx_q.size(), n);
    endtask

    task automatic chk_rsp(input string tag, input int pos, input int idx,
                           input logic [N-1:0] q, input logic [N-1:0] r, input logic e);
        chk({tag, "_idx"}, rsp_idx_q[pos], idx);
        chk({tag, "_q"},   rsp_qq[pos],    q);
        chk({tag, "_r"},   rsp_rq[pos],    r);
        chk({tag, "_err"}, rsp_eq[pos],    e);
    endtask

    task automatic do_reset();
        @(posedge pixelclk); #1;
        bus.req_valid = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge pixelclk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int rb, ab, s0;
        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        repeat (3) @(posedge pixelclk);
        #1;

        // reset state
        chk("rst_busy",   busy,              0);
        chk("rst_ready",  bus.req_ready,     0);
        chk("rst_rspv",   bus.rsp_valid,     0);
        chk("rst_start",  bus.div_start,     0);
        chk("rst_sticky", err_sticky,        0);
        chk("rst_q",      bus.rsp_quotient,  0);
        chk("rst_err",    bus.rsp_err,       0);
        rst_n = 1'b1;
        cyc1();

        // single request, latency 17
        dm_mode = 0; dm_lat = 17;
        s0 = n_start; rb = rsp_idx_q.size(); ab = acc_q.size();
        set_req(0, 16'd100, 16'd7);
        #1;
        chk("t1_ready", bus.req_ready, 4'b0001);
        wait_rsp(rb + 1, 100, "t1");
        chk("t1_acc",    acc_q.size() - ab, 1);
        chk("t1_starts", n_start - s0,      1);
        chk_rsp("t1", rb, 0, 16'd14, 16'd2, 1'b0);
        chk("t1_lat",    rsp_cyc - start_cyc, 18);
        chk("t1_busy",   busy, 0);
        chk("t1_hold_q", bus.rsp_quotient, 16'd14);

        // all four from reset, then 0 and 3 with last_grant=3
        do_reset();
        dm_lat = 5;
        rb = rsp_idx_q.size(); s0 = n_start;
        set_req(0, 16'd200,   16'd9);
        set_req(1, 16'd1000,  16'd33);
        set_req(2, 16'd65535, 16'd256);
        set_req(3, 16'd7,     16'd9);
        wait_rsp(rb + 4, 200, "t2");
        chk_rsp("t2a", rb + 0, 0, 16'd22,  16'd2,   1'b0);
        chk_rsp("t2b", rb + 1, 1, 16'd30,  16'd10,  1'b0);
        chk_rsp("t2c", rb + 2, 2, 16'd255, 16'd255, 1'b0);
        chk_rsp("t2d", rb + 3, 3, 16'd0,   16'd7,   1'b0);
        rb = rsp_idx_q.size();
        set_req(0, 16'd50, 16'd5);
        set_req(3, 16'd99, 16'd10);
        wait_rsp(rb + 2, 100, "t2w");
        chk_rsp("t2e", rb + 0, 0, 16'd10, 16'd0, 1'b0);
        chk_rsp("t2f", rb + 1, 3, 16'd9,  16'd9, 1'b0);
        chk("t2_starts", n_start - s0, 6);
        chk("t2_rsps",   rsp_idx_q.size() - (rb - 4), 6);

        // divider hang -> timeout abort, then a normal operation
        dm_mode = 1;
        rb = rsp_idx_q.size();
        set_req(1, 16'd123, 16'd4);
        wait_rsp(rb + 1, 200, "t3");
        chk_rsp("t3", rb, 1, 16'd0, 16'd0, 1'b1);
        chk("t3_lat",    rsp_cyc - start_cyc, 64);
        chk("t3_sticky", err_sticky, 1);
        dm_mode = 0; dm_lat = 5;
        rb = rsp_idx_q.size();
        set_req(1, 16'd123, 16'd4);
        wait_rsp(rb + 1, 100, "t3n");
        chk_rsp("t3n", rb, 1, 16'd30, 16'd3, 1'b0);
        chk("t3n_sticky", err_sticky, 1);

        // zero divisor on requester 2
        s0 = n_start; rb = rsp_idx_q.size();
        set_req(2, 16'd500, 16'd0);
        wait_rsp(rb + 1, 100, "t4");
`ifdef DIV_ZERO_GUARD_EN
        chk("t4_starts", n_start - s0, 0);
        chk_rsp("t4", rb, 2, 16'hFFFF, 16'd500, 1'b0);
`else
        chk("t4_starts", n_start - s0, 1);
        chk_rsp("t4", rb, 2, 16'hABCD, 16'h54A1, 1'b0);
`endif

        // reset during WAIT, stray completion two cycles after release
        dm_mode = 1;
        s0 = n_start;
        set_req(2, 16'd1000, 16'd10);
        for (int k = 0; k < 20 && n_start == s0; k++) cyc1();
        chk("t5_started", n_start - s0, 1);
        repeat (3) cyc1();
        chk("t5_busy_wait", busy, 1);
        rb = rsp_idx_q.size();
        rst_n = 1'b0;
        #1;
        chk("t5_busy_rst", busy, 0);
        chk("t5_rspv_rst", bus.rsp_valid, 0);
        repeat (2) cyc1();
        rst_n = 1'b1;
        cyc1();
        dm_stray_req++;
        repeat (4) cyc1();
        chk("t5_no_rsp",  rsp_idx_q.size() - rb, 0);
        chk("t5_idle",    busy, 0);
        chk("t5_q_clear", bus.rsp_quotient, 0);
        chk("t5_sticky",  err_sticky, 0);
        dm_mode = 0; dm_lat = 4;
        set_req(0, 16'd81, 16'd9);
        set_req(3, 16'd17, 16'd5);
        wait_rsp(rb + 2, 100, "t5r");
        chk_rsp("t5a", rb + 0, 0, 16'd9, 16'd0, 1'b0);
        chk_rsp("t5b", rb + 1, 3, 16'd3, 16'd2, 1'b0);

        // done coincident with timeout
        do_reset();
        dm_lat = 63;
        rb = rsp_idx_q.size();
        set_req(1, 16'd40000, 16'd3);
        wait_rsp(rb + 1, 200, "t6");
        chk_rsp("t6", rb, 1, 16'd13333, 16'd1, 1'b0);
        chk("t6_lat",    rsp_cyc - start_cyc, 64);
        chk("t6_sticky", err_sticky, 0);

        chk("onehot", bad_oh, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
